// File: rtl/pb_boot_pkg.sv
// Shared types and constants for the Picoblaze boot/recovery sequencer.
package pb_boot_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StHold     = 3'd3,
        StRun      = 3'd4
    } state_e;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_WDT  = 2'd2;

    localparam logic [7:0] FAULT_SAT = 8'd255;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pb_boot_sequencer.sv
// Holds the Picoblaze in reset until DCM lock is stable; re-sequences on lock loss
// or watchdog timeout and records a saturating fault count plus the last cause.
module pb_boot_sequencer
    import pb_boot_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = 16,
    parameter int unsigned RESET_HOLD_CYCLES  = 32,
    parameter int unsigned WDT_TIMEOUT        = 1024
) (
    input  logic       CLK_IN,
    input  logic       RESET_N_IN,
    input  logic       LOCKED,
    input  logic       WDT_KICK,
    output logic       CPU_RESET,
    output logic       READY,
    output logic [2:0] STATE,
    output logic [7:0] FAULT_COUNT,
    output logic [1:0] LAST_CAUSE
);

    localparam int unsigned StabW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int unsigned HoldW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam int unsigned WdtW  = (WDT_TIMEOUT > 1) ? $clog2(WDT_TIMEOUT) : 1;

    localparam logic [StabW-1:0] StabLast = StabW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RESET_HOLD_CYCLES - 1);

    logic             lock_s;
    logic             wdt_hit;
    state_e           state_q;
    logic [StabW-1:0] stab_cnt_q;
    logic [HoldW-1:0] hold_cnt_q;
    logic             cpu_reset_q;
    logic             ready_q;
    logic [7:0]       fault_cnt_q;
    logic [1:0]       last_cause_q;

    sync_2ff u_lock_sync (
        .clk_i  (CLK_IN),
        .rst_ni (RESET_N_IN),
        .d_i    (LOCKED),
        .q_o    (lock_s)
    );

    // Kick has priority over expiry; the counter idles at zero outside RUN so it
    // is already cleared on RUN entry.
    if (WDT_TIMEOUT != 0) begin : g_wdt
        logic [WdtW-1:0] wdt_q;

        assign wdt_hit = (state_q == StRun) && !WDT_KICK &&
                         (wdt_q == WdtW'(WDT_TIMEOUT - 1));

        always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
            if (!RESET_N_IN) begin
                wdt_q <= '0;
            end else if ((state_q != StRun) || WDT_KICK || wdt_hit) begin
                wdt_q <= '0;
            end else begin
                wdt_q <= wdt_q + 1'b1;
            end
        end
    end else begin : g_no_wdt
        assign wdt_hit = 1'b0;
    end

    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state_q      <= StIdle;
            stab_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            cpu_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            fault_cnt_q  <= '0;
            last_cause_q <= CAUSE_NONE;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_q <= StWaitLock;
                end
                StWaitLock: begin
                    if (lock_s) begin
                        state_q    <= StStable;
                        stab_cnt_q <= '0;
                    end
                end
                StStable: begin
                    if (!lock_s) begin
                        state_q <= StWaitLock;
                    end else if (stab_cnt_q == StabLast) begin
                        state_q    <= StHold;
                        hold_cnt_q <= '0;
                    end else begin
                        stab_cnt_q <= stab_cnt_q + 1'b1;
                    end
                end
                StHold: begin
                    if (!lock_s) begin
                        state_q <= StWaitLock;
                    end else if (hold_cnt_q == HoldLast) begin
                        state_q     <= StRun;
                        cpu_reset_q <= 1'b0;
                        ready_q     <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    // Lock loss outranks a coincident watchdog expiry.
                    if (!lock_s || wdt_hit) begin
                        cpu_reset_q <= 1'b1;
                        ready_q     <= 1'b0;
                        if (fault_cnt_q != FAULT_SAT) begin
                            fault_cnt_q <= fault_cnt_q + 8'd1;
                        end
                        if (!lock_s) begin
                            state_q      <= StWaitLock;
                            last_cause_q <= CAUSE_LOCK;
                        end else begin
                            state_q      <= StHold;
                            hold_cnt_q   <= '0;
                            last_cause_q <= CAUSE_WDT;
                        end
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    cpu_reset_q <= 1'b1;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    assign CPU_RESET   = cpu_reset_q;
    assign READY       = ready_q;
    assign STATE       = state_q;
    assign FAULT_COUNT = fault_cnt_q;
    assign LAST_CAUSE  = last_cause_q;

endmodule

// File: tb/tb_pb_boot_sequencer.sv
// Directed bench for pb_boot_sequencer: boot, lock loss, watchdog, priority,
// saturation and asynchronous reset, with hand-derived edge counts.
module tb_pb_boot_sequencer;

    localparam int unsigned Wdt = 128;

    logic       clk;
    logic       rst_n;
    logic       locked;
    logic       kick;
    logic       cpu_reset;
    logic       ready;
    logic [2:0] state;
    logic [7:0] fault_count;
    logic [1:0] last_cause;

    int total = 0;
    int bad   = 0;

    pb_boot_sequencer #(
        .LOCK_STABLE_CYCLES (16),
        .RESET_HOLD_CYCLES  (32),
        .WDT_TIMEOUT        (Wdt)
    ) dut (
        .CLK_IN      (clk),
        .RESET_N_IN  (rst_n),
        .LOCKED      (locked),
        .WDT_KICK    (kick),
        .CPU_RESET   (cpu_reset),
        .READY       (ready),
        .STATE       (state),
        .FAULT_COUNT (fault_count),
        .LAST_CAUSE  (last_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_kick();
        kick = 1'b1;
        tick(1);
        kick = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b1;
        locked = 1'b0;
        kick   = 1'b0;
        #1;
        rst_n  = 1'b0;
        tick(10);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_ready", ready, 0);
        check("rst_state", state, 0);
        check("rst_fault_count", fault_count, 0);
        check("rst_last_cause", last_cause, 0);

        // Clean boot: lock rises at cycle 20, RUN 51 edges later
        rst_n = 1'b1;
        tick(1);
        check("idle_to_wait", state, 1);
        tick(9);
        locked = 1'b1;
        tick(2);
        check("boot_wait_sync", state, 1);
        tick(1);
        check("boot_stable", state, 2);
        tick(15);
        check("boot_stable_end", state, 2);
        tick(1);
        check("boot_hold", state, 3);
        tick(31);
        check("boot_edge50_state", state, 3);
        check("boot_edge50_cpu_reset", cpu_reset, 1);
        tick(1);
        check("boot_edge51_cpu_reset", cpu_reset, 0);
        check("boot_ready", ready, 1);
        check("boot_state_run", state, 4);
        check("boot_fault_count", fault_count, 0);

        // Lock loss in RUN: reset reasserts 3 edges after LOCKED falls
        locked = 1'b0;
        tick(2);
        check("loss_edge2_cpu_reset", cpu_reset, 0);
        tick(1);
        check("loss_edge3_cpu_reset", cpu_reset, 1);
        check("loss_state", state, 1);
        check("loss_cause", last_cause, 1);
        check("loss_fault_count", fault_count, 1);
        locked = 1'b1;
        tick(50);
        check("relock_edge50", cpu_reset, 1);
        tick(1);
        check("relock_edge51", cpu_reset, 0);
        check("relock_state", state, 4);

        // Periodic kicks keep RUN alive
        for (int i = 0; i < 20; i++) begin
            tick(99);
            do_kick();
        end
        check("kick_state", state, 4);
        check("kick_fault_count", fault_count, 1);

        // Kicks stop: fault Wdt edges after the last kick
        tick(Wdt - 1);
        check("wdt_pre_state", state, 4);
        tick(1);
        check("wdt_state_hold", state, 3);
        check("wdt_cpu_reset", cpu_reset, 1);
        check("wdt_cause", last_cause, 2);
        check("wdt_fault_count", fault_count, 2);
        tick(31);
        check("wdt_hold_end", state, 3);
        tick(1);
        check("wdt_back_run", state, 4);

        // Kick on the expiry cycle wins
        tick(Wdt - 1);
        do_kick();
        check("bound_kick_state", state, 4);
        check("bound_kick_fault_count", fault_count, 2);
        tick(Wdt - 1);
        check("bound_after_kick_run", state, 4);
        tick(1);
        check("bound_after_kick_hold", state, 3);
        check("bound_after_kick_count", fault_count, 3);
        tick(32);
        check("bound_rerun", state, 4);

        // lock_s falls on the same edge the watchdog expires
        tick(Wdt - 3);
        locked = 1'b0;
        tick(2);
        check("both_pre_state", state, 4);
        tick(1);
        check("both_state", state, 1);
        check("both_cause", last_cause, 1);
        check("both_fault_count", fault_count, 4);
        tick(1);
        check("both_count_once", fault_count, 4);

        // Unstable lock: drop out of STABLE without a fault, then full restart
        locked = 1'b1;
        tick(8);
        check("unstable_in_stable", state, 2);
        locked = 1'b0;
        tick(3);
        check("unstable_back_wait", state, 1);
        check("unstable_cpu_reset", cpu_reset, 1);
        locked = 1'b1;
        tick(50);
        check("unstable_edge50", cpu_reset, 1);
        tick(1);
        check("unstable_edge51", cpu_reset, 0);
        check("unstable_fault_count", fault_count, 4);

        // Saturation through repeated watchdog faults
        for (int i = 0; i < 300; i++) begin
            tick(Wdt);
            tick(32);
        end
        check("sat_fault_count", fault_count, 255);
        check("sat_cause", last_cause, 2);
        check("sat_state", state, 4);

        // Asynchronous reset mid-HOLD, no clock edge in between
        tick(Wdt);
        tick(5);
        check("pre_rst_hold", state, 3);
        rst_n = 1'b0;
        #2;
        check("async_state", state, 0);
        check("async_cpu_reset", cpu_reset, 1);
        check("async_ready", ready, 0);
        check("async_fault_count", fault_count, 0);
        check("async_last_cause", last_cause, 0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("restart_wait", state, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pb_boot_sequencer.md
# pb_boot_sequencer

Power-up and recovery sequencer for the Picoblaze subsystem. It sits between the clock/reset block (DCM `LOCKED`) and the Picoblaze core's reset input. It holds the processor in reset until the DCM has been locked and stable, then releases it. It re-sequences the processor on loss of lock or a watchdog timeout, and keeps a saturating fault counter and the last fault cause for software and debug.

## Interface
- `LOCK_STABLE_CYCLES`, default 16: consecutive synchronized-lock cycles required before leaving STABLE (≥1).
- `RESET_HOLD_CYCLES`, default 32: cycles `CPU_RESET` is held in HOLD (≥1).
- `WDT_TIMEOUT`, default 1024: RUN cycles without a kick before a watchdog fault; 0 disables the watchdog.
- `CLK_IN  in  1`: system clock; all logic on its rising edge.
- `RESET_N_IN  in  1`: asynchronous, active-low reset.
- `LOCKED  in  1`: DCM lock, asynchronous to `CLK_IN`.
- `WDT_KICK  in  1`: single-cycle watchdog kick strobe from a Picoblaze output-port decode.
- `CPU_RESET  out  1`: active-high reset to the Picoblaze core.
- `READY  out  1`: high only in RUN.
- `STATE  out  3`: current state encoding.
- `FAULT_COUNT  out  8`: saturating count of RUN exits caused by faults.
- `LAST_CAUSE  out  2`: 0 none, 1 lock loss, 2 watchdog.

## Operation
- `LOCKED` passes through a 2-FF synchronizer to form `lock_s`. No other input is synchronized.
- State encodings: IDLE=0, WAIT_LOCK=1, STABLE=2, HOLD=3, RUN=4.
- IDLE → WAIT_LOCK unconditionally, on the first edge after reset release.
- WAIT_LOCK → STABLE when `lock_s`=1. The stability counter is cleared on entry.
- STABLE:
  - If `lock_s`=0, return to WAIT_LOCK. This is not a fault.
  - Otherwise count. After `LOCK_STABLE_CYCLES` cycles in STABLE, go to HOLD.
- HOLD:
  - If `lock_s`=0, go to WAIT_LOCK.
  - After `RESET_HOLD_CYCLES` cycles, go to RUN. The watchdog counter is cleared on entry to RUN.
- RUN:
  - `lock_s`=0: go to WAIT_LOCK, set `LAST_CAUSE`=1, and increment `FAULT_COUNT`.
  - Watchdog counter reaches `WDT_TIMEOUT`: go to HOLD, set `LAST_CAUSE`=2, and increment `FAULT_COUNT`.
  - `WDT_KICK`=1 clears the watchdog counter.
- `CPU_RESET`=1 in every state except RUN. `READY` = (state==RUN).
- `WDT_KICK` is ignored outside RUN.
- `FAULT_COUNT` saturates at 255.
- `FAULT_COUNT` and `LAST_CAUSE` are cleared only by `RESET_N_IN`.

## Timing
- Reset values: state IDLE, `CPU_RESET`=1, `READY`=0, `STATE`=0, `FAULT_COUNT`=0, `LAST_CAUSE`=0, synchronizer flops 0, all counters 0.
- All outputs are registered and reflect the state register directly. There is no combinational input-to-output path.
- Lock-up latency: `LOCKED` rising gives `lock_s` high 2 edges later. The machine then spends 1 edge (WAIT_LOCK→STABLE), `LOCK_STABLE_CYCLES` edges, and `RESET_HOLD_CYCLES` edges. With defaults, `CPU_RESET` falls 51 edges after the first edge sampling `LOCKED`=1.
- Lock-loss latency: `LOCKED` falling gives `CPU_RESET` high 3 edges later (2 synchronizer edges plus 1 state edge).
- Watchdog: with no kick after RUN entry, `CPU_RESET` rises `WDT_TIMEOUT` edges after the RUN entry edge.
- A kick on the cycle the counter would reach `WDT_TIMEOUT` wins: the counter clears and there is no fault.
- Lock loss and watchdog timeout on the same cycle: lock loss wins. The next state is WAIT_LOCK, `LAST_CAUSE`=1, and `FAULT_COUNT` increments once.
- Lock glitch shorter than 2 clock periods: it may be missed by the synchronizer. That is acceptable.
- `RESET_N_IN` asserted mid-sequence: all outputs reach their reset values immediately (asynchronously). Deassertion restarts from IDLE.

## Structure
- Package `pb_boot_pkg` holds:
  - state enum/localparams (IDLE..RUN);
  - cause codes (`CAUSE_NONE`, `CAUSE_LOCK`, `CAUSE_WDT`);
  - the `FAULT_COUNT` saturation value.
- Sub-module `sync_2ff`: a 1-bit two-flop synchronizer with async active-low reset, reusable for `SWITCHES` inputs.
- Counter widths are derived with `$clog2` of each parameter (minimum 1). The WDT counter is omitted when `WDT_TIMEOUT`=0.

## Test plan
- **Clean boot:** reset low 10 cycles, release, `LOCKED` rises at cycle 20 → `CPU_RESET` falls 51 edges later; `READY`=1; `STATE`=4; `FAULT_COUNT`=0.
- **Unstable lock:** `LOCKED` high 8 cycles, low, then high → machine returns to WAIT_LOCK; `CPU_RESET` stays 1; the full 51-edge sequence restarts from the final rise; `FAULT_COUNT`=0.
- **Lock loss in RUN:** drop `LOCKED` → `CPU_RESET`=1 three edges later; `LAST_CAUSE`=1; `FAULT_COUNT`=1. Re-lock → RUN again after 51 edges.
- **Watchdog:** kick every 500 cycles for 5000 cycles → no fault. Stop kicking → `CPU_RESET` rises 1024 edges after the last kick; `LAST_CAUSE`=2; HOLD 32 cycles; back in RUN.
- **Simultaneous faults and kick boundary:** drop `LOCKED` timed so `lock_s` falls on the timeout cycle → WAIT_LOCK, `LAST_CAUSE`=1, count +1 only. Separately, kick exactly on the timeout cycle → no fault.
- **Saturation and reset:** force 300 watchdog faults → `FAULT_COUNT`=255. Assert `RESET_N_IN` mid-HOLD → all outputs at reset values the same cycle, with no clock edge required.
